pmu_tap_rx: RTL and testbench

PMU_TAP_RX -- requirements
Module: pmu_tap_rx

---
 rtl/pmu_tap_rx_pkg.sv | 27 ++
 rtl/pmu_tap_rx_tap_fsm.sv | 37 +++
 rtl/pmu_tap_rx.sv | 122 ++++++++++++
 tb/tb_pmu_tap_rx.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pmu_tap_rx_pkg.sv
// Shared PMU TAP definitions: state encoding and instruction codes.
package pmu_tap_rx_pkg;

    // IEEE 1149.1 customary 4-bit state encoding
    typedef enum logic [3:0] {
        TAP_EXIT2_DR = 4'h0,
        TAP_EXIT1_DR = 4'h1,
        TAP_SHIFT_DR = 4'h2,
        TAP_PAUSE_DR = 4'h3,
        TAP_SEL_IR   = 4'h4,
        TAP_UPD_DR   = 4'h5,
        TAP_CAP_DR   = 4'h6,
        TAP_SEL_DR   = 4'h7,
        TAP_EXIT2_IR = 4'h8,
        TAP_EXIT1_IR = 4'h9,
        TAP_SHIFT_IR = 4'hA,
        TAP_PAUSE_IR = 4'hB,
        TAP_RTI      = 4'hC,
        TAP_UPD_IR   = 4'hD,
        TAP_CAP_IR   = 4'hE,
        TAP_TLR      = 4'hF
    } tap_state_e;

    localparam logic [4:0] TAP_INSN_HEADER = 5'h1B;
    localparam logic [4:0] TAP_INSN_BYPASS = 5'h1F;

endpackage

// File: rtl/pmu_tap_rx_tap_fsm.sv
// 16-state JTAG TAP controller, one transition per clock edge.
module tap_fsm
    import pmu_tap_rx_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tms_i,
    output tap_state_e state
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= TAP_TLR;
        end else begin
            case (state)
                TAP_TLR:      state <= tms_i ? TAP_TLR      : TAP_RTI;
                TAP_RTI:      state <= tms_i ? TAP_SEL_DR   : TAP_RTI;
                TAP_SEL_DR:   state <= tms_i ? TAP_SEL_IR   : TAP_CAP_DR;
                TAP_CAP_DR:   state <= tms_i ? TAP_EXIT1_DR : TAP_SHIFT_DR;
                TAP_SHIFT_DR: state <= tms_i ? TAP_EXIT1_DR : TAP_SHIFT_DR;
                TAP_EXIT1_DR: state <= tms_i ? TAP_UPD_DR   : TAP_PAUSE_DR;
                TAP_PAUSE_DR: state <= tms_i ? TAP_EXIT2_DR : TAP_PAUSE_DR;
                TAP_EXIT2_DR: state <= tms_i ? TAP_UPD_DR   : TAP_SHIFT_DR;
                TAP_UPD_DR:   state <= tms_i ? TAP_SEL_DR   : TAP_RTI;
                TAP_SEL_IR:   state <= tms_i ? TAP_TLR      : TAP_CAP_IR;
                TAP_CAP_IR:   state <= tms_i ? TAP_EXIT1_IR : TAP_SHIFT_IR;
                TAP_SHIFT_IR: state <= tms_i ? TAP_EXIT1_IR : TAP_SHIFT_IR;
                TAP_EXIT1_IR: state <= tms_i ? TAP_UPD_IR   : TAP_PAUSE_IR;
                TAP_PAUSE_IR: state <= tms_i ? TAP_EXIT2_IR : TAP_PAUSE_IR;
                TAP_EXIT2_IR: state <= tms_i ? TAP_UPD_IR   : TAP_SHIFT_IR;
                TAP_UPD_IR:   state <= tms_i ? TAP_SEL_DR   : TAP_RTI;
                default:      state <= TAP_TLR;
            endcase
        end
    end

endmodule

// File: rtl/pmu_tap_rx.sv
// PMU TAP receiver: IR/bypass/header data registers and a valid/ready header handoff.
module pmu_tap_rx
    import pmu_tap_rx_pkg::*;
#(
    parameter int               IR_W        = 5,
    parameter int               HDR_W       = 32,
    parameter logic [IR_W-1:0]  INSN_HEADER = IR_W'(TAP_INSN_HEADER),
    parameter logic [IR_W-1:0]  INSN_BYPASS = IR_W'(TAP_INSN_BYPASS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tms_i,
    input  logic             tdi_i,
    output logic             td_o,
    output logic [3:0]       tap_state_o,
    output logic [IR_W-1:0]  ir_o,
    output logic [HDR_W-1:0] hdr_data_o,
    output logic             hdr_valid_o,
    input  logic             hdr_ready_i,
    output logic             overrun_o
);

    localparam int CNT_W = $clog2(HDR_W + 1);

    tap_state_e        state;
    logic [IR_W-1:0]   ir_sr;
    logic [HDR_W-1:0]  hdr_sr;
    logic [CNT_W-1:0]  cnt;
    logic              byp;
    logic              armed;
    logic              pend;
    logic              hdr_sel;
    logic              hdr_shift;
    logic              to_tlr;

    tap_fsm u_fsm (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .tms_i (tms_i),
        .state (state)
    );

    assign tap_state_o = state;
    assign hdr_sel     = (ir_o == INSN_HEADER);
    // ir_o already shows BYPASS on the edge that lands in Test-Logic-Reset
    assign to_tlr      = tms_i && (state == TAP_TLR || state == TAP_SEL_IR);
    assign hdr_shift   = (armed && state == TAP_RTI && !tms_i) ||
                         (state == TAP_SHIFT_DR && hdr_sel && cnt != CNT_W'(HDR_W));

    always_comb begin
        td_o = 1'b0;
        if (state == TAP_SHIFT_IR)      td_o = ir_sr[0];
        else if (state == TAP_SHIFT_DR) td_o = hdr_sel ? hdr_sr[0] : byp;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ir_sr       <= '0;
            ir_o        <= INSN_BYPASS;
            hdr_sr      <= '0;
            cnt         <= '0;
            byp         <= 1'b0;
            armed       <= 1'b0;
            pend        <= 1'b0;
            hdr_data_o  <= '0;
            hdr_valid_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            pend <= 1'b0;
            case (state)
                TAP_CAP_IR:   ir_sr <= IR_W'(2'b01);
                TAP_SHIFT_IR: ir_sr <= {tdi_i, ir_sr[IR_W-1:1]};
                TAP_UPD_IR:   ir_o  <= ir_sr;
                TAP_CAP_DR: begin
                    byp <= 1'b0;
                    if (hdr_sel) begin
                        hdr_sr <= '0;
                        cnt    <= '0;
                    end
                end
                TAP_SHIFT_DR: byp <= tdi_i;
                default: ;
            endcase

            if (to_tlr) begin
                ir_o  <= INSN_BYPASS;
                armed <= 1'b0;
            end

            if (state == TAP_UPD_IR && !tms_i && ir_sr == INSN_HEADER) begin
                armed  <= 1'b1;
                cnt    <= '0;
                hdr_sr <= '0;
            end else if (state == TAP_RTI && tms_i) begin
                // a partial idle-load word is thrown away on exit
                armed <= 1'b0;
                if (armed) cnt <= '0;
            end

            if (hdr_shift) begin
                hdr_sr <= {tdi_i, hdr_sr[HDR_W-1:1]};
                cnt    <= cnt + 1'b1;
                if (cnt == CNT_W'(HDR_W - 1)) begin
                    pend  <= 1'b1;
                    armed <= 1'b0;
                end
            end

            if (pend) begin
                if (!hdr_valid_o || hdr_ready_i) begin
                    hdr_data_o  <= hdr_sr;
                    hdr_valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (hdr_valid_o && hdr_ready_i) begin
                hdr_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pmu_tap_rx.sv
// Self-checking bench for pmu_tap_rx: header words tracked through a scoreboard queue.
module tb_pmu_tap_rx;
    import pmu_tap_rx_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i, tms_i, tdi_i, hdr_ready_i;
    logic        td_o, hdr_valid_o, overrun_o;
    logic [3:0]  tap_state_o;
    logic [4:0]  ir_o;
    logic [31:0] hdr_data_o;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_word;

    always #5 clk = ~clk;

    pmu_tap_rx dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .tms_i       (tms_i),
        .tdi_i       (tdi_i),
        .td_o        (td_o),
        .tap_state_o (tap_state_o),
        .ir_o        (ir_o),
        .hdr_data_o  (hdr_data_o),
        .hdr_valid_o (hdr_valid_o),
        .hdr_ready_i (hdr_ready_i),
        .overrun_o   (overrun_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic tms, input logic tdi);
        tms_i = tms;
        tdi_i = tdi;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_chk(input string tag);
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %h", tag, hdr_data_o);
        end else begin
            last_word = exp_q.pop_front();
            chk(tag, hdr_data_o, last_word);
        end
    endtask

    // from Run-Test/Idle: Select-DR, Select-IR, Capture-IR, Shift-IR x IR_W, Update-IR, Idle
    task automatic load_ir(input logic [4:0] insn);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 5; i++) step(i == 4, insn[i]);
        step(1, 0);
        step(0, 0);
    endtask

    // idle-load word: 32 bits in Run-Test/Idle, then the transfer edge
    task automatic idle_word(input logic [31:0] w, input string tag);
        exp_q.push_back(w);
        for (int i = 0; i < 32; i++) step(0, w[i]);
        chk({tag, "_valid_before_xfer"}, 32'(hdr_valid_o), 32'd0);
        step(0, 0);
        chk({tag, "_valid"}, 32'(hdr_valid_o), 32'd1);
        pop_chk({tag, "_data"});
    endtask

    // Shift-DR word from Idle; last shift edge exits, transfer edge enters Update-DR
    task automatic dr_word(input logic [31:0] w, input logic rdy_xfer, input logic push);
        if (push) exp_q.push_back(w);
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 32; i++) step(i == 31, w[i]);
        hdr_ready_i = rdy_xfer;
        step(1, 0);
        hdr_ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int tms_a[12] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        int tdi_a[12] = '{0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0};
        rst_i = 1'b1; tms_i = 1'b0; tdi_i = 1'b0; hdr_ready_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_state", 32'(tap_state_o), 32'(TAP_TLR));
        chk("rst_ir", 32'(ir_o), 32'h1F);
        chk("rst_valid", 32'(hdr_valid_o), 32'd0);
        chk("rst_data", hdr_data_o, 32'd0);
        chk("rst_overrun", 32'(overrun_o), 32'd0);
        chk("rst_td", 32'(td_o), 32'd0);
        rst_i = 1'b0;

        for (int i = 0; i < 12; i++) begin
            step(tms_a[i][0], tdi_a[i][0]);
            if (i == 4) chk("capir_td", 32'(td_o), 32'd1);
        end
        chk("ir_load", 32'(ir_o), 32'h1B);
        chk("ir_state", 32'(tap_state_o), 32'(TAP_RTI));

        idle_word(32'h0000_0017, "idle1");
        for (int i = 0; i < 3; i++) step(0, 1);
        chk("hold_valid", 32'(hdr_valid_o), 32'd1);
        chk("hold_data", hdr_data_o, last_word);
        hdr_ready_i = 1'b1;
        step(0, 0);
        hdr_ready_i = 1'b0;
        chk("accept_valid", 32'(hdr_valid_o), 32'd0);

        step(1, 0); step(0, 0); step(0, 0);
        chk("shdr_state", 32'(tap_state_o), 32'(TAP_SHIFT_DR));
        for (int i = 0; i < 5; i++) step(1, 0);
        chk("tlr_state", 32'(tap_state_o), 32'(TAP_TLR));
        chk("tlr_ir", 32'(ir_o), 32'h1F);

        // bypass path
        step(0, 0); step(1, 0); step(0, 0); step(0, 0);
        chk("byp_cap_td", 32'(td_o), 32'd0);
        step(0, 1);
        chk("byp_shift_td", 32'(td_o), 32'd1);
        step(1, 0); step(1, 0); step(0, 0);

        load_ir(5'h1B);
        chk("reload_ir", 32'(ir_o), 32'h1B);
        idle_word(32'h0000_0017, "idle2");
        dr_word(32'hA5A5_A5A5, 1'b0, 1'b0);
        chk("ovr_flag", 32'(overrun_o), 32'd1);
        chk("ovr_valid", 32'(hdr_valid_o), 32'd1);
        chk("ovr_data_kept", hdr_data_o, last_word);
        step(0, 0);
        dr_word(32'h1234_5678, 1'b1, 1'b1);
        chk("same_edge_valid", 32'(hdr_valid_o), 32'd1);
        pop_chk("same_edge_data");
        chk("same_edge_ovr_sticky", 32'(overrun_o), 32'd1);
        step(0, 0);
        hdr_ready_i = 1'b1;
        step(0, 0);
        hdr_ready_i = 1'b0;
        chk("accept2_valid", 32'(hdr_valid_o), 32'd0);

        load_ir(5'h1B);
        for (int i = 0; i < 20; i++) step(0, 1'($urandom_range(0, 1)));
        step(1, 0);
        step(0, 0); step(1, 0); step(1, 0); step(0, 0);
        for (int i = 0; i < 3; i++) step(0, 1);
        chk("partial_valid", 32'(hdr_valid_o), 32'd0);
        chk("partial_state", 32'(tap_state_o), 32'(TAP_RTI));
        load_ir(5'h1B);
        idle_word(32'hCAFE_0123, "fresh");
        chk("fresh_ovr_sticky", 32'(overrun_o), 32'd1);

        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 16; i++) step(0, 1'($urandom_range(0, 1)));
        chk("midshift_state", 32'(tap_state_o), 32'(TAP_SHIFT_IR));
        rst_i = 1'b1;
        step(0, 1);
        rst_i = 1'b0;
        chk("mrst_state", 32'(tap_state_o), 32'(TAP_TLR));
        chk("mrst_ir", 32'(ir_o), 32'h1F);
        chk("mrst_data", hdr_data_o, 32'd0);
        chk("mrst_valid", 32'(hdr_valid_o), 32'd0);
        chk("mrst_overrun", 32'(overrun_o), 32'd0);
        chk("mrst_td", 32'(td_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
